// File: rtl/wdg_rst_gen_pkg.sv
// wdg_pkg: shared state encoding and default constants for the watchdog reset generator
// Contents: state_t FSM enum, default pulse/hold-off lengths, irq2 synchroniser reset value.
package wdg_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLDOFF = 2'd2} state_t;
  localparam int DEF_RST_PULSE_CYCLES = 16;
  localparam int DEF_HOLDOFF_CYCLES = 64;
  localparam logic IRQ2_SYNC_RST = 1'b1;
endpackage

// File: rtl/wdg_rst_gen_if.sv
// wdg_rst_gen_if: watchdog timeout inputs and reset/interrupt outputs of wdg_rst_gen
// master: watchdog/CPU side (drives i_*, observes o_*); slave: wdg_rst_gen itself.
interface wdg_rst_gen_if #(parameter int RSTCNT_WIDTH = 4);
  logic i_irq1;
  logic i_irq2;
  logic i_irq_mask;
  logic i_flag_clr;
  logic o_cpu_irq;
  logic o_sys_rst;
  logic o_wdg_rst_flag;
  logic [RSTCNT_WIDTH-1:0] o_rst_count;
  logic o_busy;
  modport master (
    output i_irq1, i_irq2, i_irq_mask, i_flag_clr,
    input  o_cpu_irq, o_sys_rst, o_wdg_rst_flag, o_rst_count, o_busy
  );
  modport slave (
    input  i_irq1, i_irq2, i_irq_mask, i_flag_clr,
    output o_cpu_irq, o_sys_rst, o_wdg_rst_flag, o_rst_count, o_busy
  );
endinterface

// File: rtl/wdg_rst_gen_sync2.sv
// wdg_sync2: two-flop synchroniser with configurable reset value
// Ports: clk, rst (async, active-high), i_d (async input), o_q (synchronised output).
module wdg_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= {2{RST_VAL}};
    else     r_sync <= {r_sync[0], i_d};
  assign o_q = r_sync[1];
endmodule

// File: rtl/wdg_rst_gen.sv
// wdg_rst_gen: turns watchdog stage-2 timeouts into a timed system reset pulse plus hold-off
// Ports: clk, res (async active-high power-on reset), bus (wdg_rst_gen_if.slave):
//   i_irq1/i_irq2 watchdog levels, i_irq_mask, i_flag_clr, o_cpu_irq, o_sys_rst,
//   o_wdg_rst_flag, o_rst_count (saturating), o_busy (FSM not idle).
// Macro WDG_RST_GEN_IRQ_SYNC_EN: pass i_irq1/i_irq2 through 2-flop synchronisers.
module wdg_rst_gen
  import wdg_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES,
  parameter int HOLDOFF_CYCLES   = DEF_HOLDOFF_CYCLES,
  parameter int CNT_WIDTH        = 8,
  parameter int RSTCNT_WIDTH     = 4
) (
  input logic          clk,
  input logic          res,
  wdg_rst_gen_if.slave bus
);
  if (RST_PULSE_CYCLES < 1 || RST_PULSE_CYCLES > 2**CNT_WIDTH ||
      HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 2**CNT_WIDTH) begin : g_bad_param
    $fatal(1, "wdg_rst_gen: RST_PULSE_CYCLES/HOLDOFF_CYCLES out of range");
  end
  localparam logic [CNT_WIDTH-1:0] PULSE_LOAD = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD  = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
  logic w_irq1, w_irq2, w_edge, w_trig, w_cnt_zero;
  logic r_irq2_q, r_cpu_irq, r_flag;
  logic [RSTCNT_WIDTH-1:0] r_rst_count;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  state_t r_state, w_state_nxt;
`ifdef WDG_RST_GEN_IRQ_SYNC_EN
  wdg_sync2 #(.RST_VAL(1'b0)) u_sync_irq1 (.clk(clk), .rst(res), .i_d(bus.i_irq1), .o_q(w_irq1));
  wdg_sync2 #(.RST_VAL(IRQ2_SYNC_RST)) u_sync_irq2 (.clk(clk), .rst(res), .i_d(bus.i_irq2), .o_q(w_irq2));
`else
  assign w_irq1 = bus.i_irq1;
  assign w_irq2 = bus.i_irq2;
`endif
  // irq2_q resets high so a level already asserted at reset release cannot trigger
  assign w_edge     = w_irq2 & ~r_irq2_q;
  assign w_trig     = (r_state == IDLE) & w_edge;
  assign w_cnt_zero = (r_cnt == '0);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_state_nxt = w_edge ? PULSE : IDLE;
        w_cnt_nxt   = w_edge ? PULSE_LOAD : r_cnt;
      end
      PULSE: begin
        w_state_nxt = w_cnt_zero ? HOLDOFF : PULSE;
        w_cnt_nxt   = w_cnt_zero ? HOLD_LOAD : r_cnt - 1'b1;
      end
      HOLDOFF: begin
        w_state_nxt = w_cnt_zero ? IDLE : HOLDOFF;
        w_cnt_nxt   = w_cnt_zero ? '0 : r_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge res)
    if (res) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  // A new trigger outranks a simultaneous clear so the latest reset is never lost
  always_ff @(posedge clk or posedge res)
    if (res) begin
      r_irq2_q    <= IRQ2_SYNC_RST;
      r_cpu_irq   <= 1'b0;
      r_flag      <= 1'b0;
      r_rst_count <= '0;
    end else begin
      r_irq2_q  <= w_irq2;
      r_cpu_irq <= w_irq1 & ~bus.i_irq_mask;
      if (w_trig) begin
        r_flag      <= 1'b1;
        r_rst_count <= bus.i_flag_clr ? RSTCNT_WIDTH'(1) :
                       (&r_rst_count) ? r_rst_count : r_rst_count + 1'b1;
      end else if (bus.i_flag_clr) begin
        r_flag      <= 1'b0;
        r_rst_count <= '0;
      end
    end
  assign bus.o_cpu_irq      = r_cpu_irq;
  assign bus.o_sys_rst      = (r_state == PULSE);
  assign bus.o_busy         = (r_state != IDLE);
  assign bus.o_wdg_rst_flag = r_flag;
  assign bus.o_rst_count    = r_rst_count;
endmodule

// File: tb/tb_wdg_rst_gen.sv
// tb_wdg_rst_gen: directed, table-driven self-checking bench for wdg_rst_gen
module tb_wdg_rst_gen;
`ifdef WDG_RST_GEN_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  typedef struct {int n; logic sys; logic busy;} pt_t;
  typedef struct {logic irq1; logic mask; logic exp;} irq_vec_t;
  logic clk = 1'b0;
  logic res = 1'b1;
  int checks = 0;
  int errors = 0;
  wdg_rst_gen_if #(.RSTCNT_WIDTH(4)) bus ();
  wdg_rst_gen dut (.clk(clk), .res(res), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic trigger_wait();
    bus.i_irq2 = 1'b1;
    repeat (3) tick();
    bus.i_irq2 = 1'b0;
    repeat (90) tick();
  endtask
  initial begin
    pt_t pts[6];
    irq_vec_t tbl[7];
    int sys_cnt, busy_cnt;
    logic prev;
    pts[0] = '{LAT - 1, 1'b0, 1'b0};
    pts[1] = '{LAT, 1'b1, 1'b1};
    pts[2] = '{LAT + 15, 1'b1, 1'b1};
    pts[3] = '{LAT + 16, 1'b0, 1'b1};
    pts[4] = '{LAT + 79, 1'b0, 1'b1};
    pts[5] = '{LAT + 80, 1'b0, 1'b0};
    tbl[0] = '{1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0};
    bus.i_irq1 = 1'b0;
    bus.i_irq2 = 1'b0;
    bus.i_irq_mask = 1'b0;
    bus.i_flag_clr = 1'b0;
    repeat (3) tick();
    check("rst_sys_rst", bus.o_sys_rst, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_flag", bus.o_wdg_rst_flag, 0);
    check("rst_count", bus.o_rst_count, 0);
    check("rst_cpu_irq", bus.o_cpu_irq, 0);
    res = 1'b0;
    repeat (5) tick();
    // first trigger with hold-off pokes at n=30 and n=50
    sys_cnt = 0;
    busy_cnt = 0;
    bus.i_irq2 = 1'b1;
    for (int n = 0; n <= 120; n++) begin
      if (n > 0) tick();
      bus.i_irq2 = (n < 25) || (n >= 30 && n < 35) || (n >= 50 && n < 55);
      sys_cnt += int'(bus.o_sys_rst);
      busy_cnt += int'(bus.o_busy);
      foreach (pts[k]) if (pts[k].n == n) begin
        check($sformatf("pulse_sys_n%0d", n), bus.o_sys_rst, pts[k].sys);
        check($sformatf("pulse_busy_n%0d", n), bus.o_busy, pts[k].busy);
      end
    end
    check("pulse_width", sys_cnt, 16);
    check("busy_width", busy_cnt, 80);
    check("trig1_flag", bus.o_wdg_rst_flag, 1);
    check("trig1_count", bus.o_rst_count, 1);
    // re-arm after hold-off; held-high level must not retrigger
    sys_cnt = 0;
    bus.i_irq2 = 1'b1;
    repeat (LAT) tick();
    check("rearm_sys_rst", bus.o_sys_rst, 1);
    check("rearm_count", bus.o_rst_count, 2);
    for (int n = LAT; n < 200; n++) begin
      sys_cnt += int'(bus.o_sys_rst);
      tick();
    end
    check("held_high_pulses", sys_cnt, 16);
    check("held_high_idle", bus.o_busy, 0);
    // reset mid-pulse drops o_sys_rst without a clock edge
    bus.i_irq2 = 1'b0;
    tick();
    bus.i_irq2 = 1'b1;
    repeat (LAT + 3) tick();
    check("mid_sys_before", bus.o_sys_rst, 1);
    #2 res = 1'b1;
    #1;
    check("mid_sys_async", bus.o_sys_rst, 0);
    check("mid_busy", bus.o_busy, 0);
    check("mid_flag", bus.o_wdg_rst_flag, 0);
    check("mid_count", bus.o_rst_count, 0);
    tick();
    res = 1'b0;
    sys_cnt = 0;
    repeat (200) begin
      tick();
      sys_cnt += int'(bus.o_sys_rst);
    end
    check("high_at_release", sys_cnt, 0);
    bus.i_irq2 = 1'b0;
    repeat (LAT + 1) tick();
    bus.i_irq2 = 1'b1;
    repeat (LAT) tick();
    check("toggle_after_rst", bus.o_sys_rst, 1);
    bus.i_irq2 = 1'b0;
    repeat (90) tick();
    check("toggle_count", bus.o_rst_count, 1);
    // saturation: 16 more triggers give 17 total
    for (int k = 2; k <= 17; k++) begin
      trigger_wait();
      if (k >= 14) check($sformatf("sat_count_%0d", k), bus.o_rst_count, (k > 15) ? 15 : k);
    end
    bus.i_irq2 = 1'b1;
    repeat (LAT - 1) tick();
    bus.i_flag_clr = 1'b1;
    tick();
    bus.i_flag_clr = 1'b0;
    check("clr_vs_set_flag", bus.o_wdg_rst_flag, 1);
    check("clr_vs_set_count", bus.o_rst_count, 1);
    bus.i_flag_clr = 1'b1;
    tick();
    bus.i_flag_clr = 1'b0;
    check("clr_flag", bus.o_wdg_rst_flag, 0);
    check("clr_count", bus.o_rst_count, 0);
    check("clr_keeps_pulse", bus.o_sys_rst, 1);
    bus.i_irq2 = 1'b0;
    repeat (90) tick();
    // cpu irq path: value must still be old one tick early, new one at LAT
    prev = 1'b0;
    foreach (tbl[k]) begin
      bus.i_irq1 = tbl[k].irq1;
      bus.i_irq_mask = tbl[k].mask;
      repeat (LAT - 1) tick();
      check($sformatf("irq_early_%0d", k), bus.o_cpu_irq, prev);
      tick();
      check($sformatf("irq_vec_%0d", k), bus.o_cpu_irq, tbl[k].exp);
      prev = tbl[k].exp;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
